uart_rx_flow: RTL
=================

Name: uart_rx_flow

Overview:
UART 8N1 receiver with a receive FIFO and RTS flow control, sitting in soc_system directly downstream of the board-level uart_rx pin (GPIO_1[3]) and driving uart_rts (GPIO_1[9]).
- Oversamples the asynchronous rx line, assembles bytes LSB-first and buffers them in a FIFO.
- Presents bytes to the core over a valid/ready handshake.
- Raises RTS with hysteresis so the external master stops sending before the FIFO overflows.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 8
FIFO_DEPTH, 16, receive FIFO entries; power of two
RTS_HIGH_WATER, 12, level at or above which rts_out asserts
RTS_LOW_WATER, 4, level at or below which rts_out deasserts; must be < RTS_HIGH_WATER

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_in  in  1  asynchronous serial input from master tx
rts_out  out  1  1 = we cannot take input (to master cts)
rx_data  out  8  head-of-FIFO byte
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts rx_data this cycle
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun_err  out  1  one-cycle pulse: byte dropped, FIFO full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: rts_out=1, rx_valid=0, rx_data=0, frame_err=0, overrun_err=0, fifo_level=0, FSM=IDLE. The two synchronizer flops reset to 1.
- Reset asserted mid-frame: the partial byte is discarded and the FIFO is emptied.
- rx_in passes through a 2-FF synchronizer (rx_s). All sampling uses rx_s.
- Bit counter and sample counter are cleared on every state entry.
- FSM states:
  - IDLE: rx_s==0 -> START.
  - START: at count CLKS_PER_BIT/2-1, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch, nothing reported).
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into bit[n], LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: push the byte, -> IDLE.
    - rx_s==0: pulse frame_err, discard the byte, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. This prevents a break condition from being taken as a start bit.
- Push timing: the push occurs in the cycle of the stop sample. The byte is visible on rx_data/rx_valid the next cycle.
- Total latency from the rx_in start-bit falling edge to rx_valid: 2 (sync) + 9.5*CLKS_PER_BIT + 1 cycles, ±1.
- FIFO is first-word-fall-through:
  - rx_valid = (level != 0).
  - Pop occurs when rx_valid && rx_ready.
  - rx_ready while empty is ignored.
- Push while full:
  - Accepted if a pop occurs in the same cycle; level is unchanged.
  - Otherwise overrun_err pulses, the byte is dropped and FIFO contents are untouched.
- Simultaneous push and pop on a non-full FIFO: level is unchanged, order is preserved.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level counter does not wrap: it is bounded to 0..FIFO_DEPTH.
- rts_out is registered:
  - Set when next-level >= RTS_HIGH_WATER.
  - Cleared when next-level <= RTS_LOW_WATER.
  - Otherwise holds its value.
- The receiver keeps accepting bytes regardless of rts_out; the master may still be mid-byte when RTS rises.

Decomposition:
- uart_pkg holds:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - localparam UART_DATA_BITS = 8
  - localparam UART_CLKS_PER_BIT_DEFAULT = 434
- One sub-module: sync_fifo. Parameters: WIDTH, DEPTH. Ports: clk, rst, push, pop, din, dout, empty, full, level. Read is FWFT; its push-when-full-with-pop rule is as above.
- The FSM, synchronizer and RTS logic live in uart_rx_flow.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) with rx_ready=1 -> rx_valid pulses for exactly one cycle with rx_data=0xA5, about 155 cycles after the start edge; fifo_level returns to 0; no error pulses.
2. Drive rx_in low for 5 cycles, then high -> FSM returns to IDLE; rx_valid, frame_err and overrun_err stay 0.
3. Send 0x3C with stop bit=0, hold rx low 40 cycles, then send 0x11 -> exactly one frame_err pulse; only 0x11 appears on rx_data; no byte pushed during the low period.
4. rx_ready=0, send 12 bytes 0x01..0x0C -> rts_out=1 the cycle after the 12th push. Then pop 7 bytes: rts_out stays 1. Pop the 8th byte -> level=4 and rts_out=0. Remaining data is 0x09..0x0C in order.
5. rx_ready=0, send 17 bytes 0x01..0x11 -> fifo_level=16; overrun_err pulses once on byte 17; popping yields 0x01..0x10.
6. Assert rst for 1 cycle during bit 4 of a frame -> all outputs at reset values; rts_out=0 one cycle after release; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_flow_sync_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_flow.sv
// UART 8N1 receiver: synchronizer, bit-timing FSM, receive FIFO and RTS flow control with hysteresis.
module uart_rx_flow
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT   = UART_CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH     = 16,
   parameter int RTS_HIGH_WATER = 12,
   parameter int RTS_LOW_WATER  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_in,
   output logic                          rts_out,
   output logic [UART_DATA_BITS-1:0]     rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);
   localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(RTS_HIGH_WATER);
   localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(RTS_LOW_WATER);

   logic [1:0]                sync_q;
   logic                      rx_s;
   uart_rx_state_t            state;
   logic [CNT_W-1:0]          clk_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      push;
   logic                      pop;
   logic                      push_ok;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic [LVL_W-1:0]          next_level;

   // Idle-high reset value keeps a line that is quiet at reset from looking like a start bit.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rx_in};
   end
   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         clk_cnt   <= clk_cnt + 1'b1;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               if (clk_cnt == HALF_END) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (clk_cnt == BIT_END) begin
                  clk_cnt <= '0;
                  shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end
               end
            end
            STOP: begin
               if (clk_cnt == BIT_END) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (rx_s) state <= IDLE;
            end
            default: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // The byte is pushed in the same cycle the good stop bit is sampled.
   assign push = (state == STOP) && (clk_cnt == BIT_END) && rx_s;

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (shift_q),
      .dout  (rx_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (fifo_level)
   );

   assign rx_valid = !fifo_empty;
   assign pop      = rx_valid && rx_ready;
   assign push_ok  = push && (!fifo_full || pop);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_level = fifo_level;
      if (push_ok && !pop)      next_level = fifo_level + 1'b1;
      else if (pop && !push_ok) next_level = fifo_level - 1'b1;
   end

   // RTS looks at the post-update level so it moves together with fifo_level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rts_out     <= 1'b1;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= push && fifo_full && !pop;
         if (next_level >= HIGH_LVL)     rts_out <= 1'b1;
         else if (next_level <= LOW_LVL) rts_out <= 1'b0;
      end
   end

endmodule
